// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the Sobel stream controller.
//   - Default geometry (512x512 frame, 16 pixels per beat) and the derived
//     beats-per-row / beats-per-frame values for that geometry.
//   - Helpers that derive the same values for other parameterisations and
//     size counters without ever producing a zero-width vector.
//   - Controller FSM state encoding.
// -----------------------------------------------------------------------------
package sobel_pkg;

    localparam int DEF_PIXELS_PER_BEAT = 16;
    localparam int DEF_IMAGE_DIM       = 512;
    localparam int DEF_BPR             = DEF_IMAGE_DIM / DEF_PIXELS_PER_BEAT;
    localparam int DEF_FRAME_BEATS     = DEF_BPR * DEF_IMAGE_DIM;

    // Width of a counter able to hold 0..n-1; never narrower than 1 bit.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    function automatic int calc_bpr(input int image_dim, input int pixels_per_beat);
        return image_dim / pixels_per_beat;
    endfunction

    localparam int DEF_COL_W  = clog2_min1(DEF_BPR);
    localparam int DEF_ROW_W  = clog2_min1(DEF_IMAGE_DIM);
    localparam int DEF_OCNT_W = clog2_min1(DEF_FRAME_BEATS + 1);

    typedef enum logic [2:0] {
        ST_CLR   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/sobel_stream_ctrl_vld_pipe.sv
// -----------------------------------------------------------------------------
// sobel_vld_pipe
// DEPTH-deep valid shift register that tracks which datapath slots hold real
// pixels. It moves only when the datapath moves, so its last stage is always
// aligned with the beat the datapath is presenting.
// Ports:
//   clk    in   clock, rising edge
//   areset in   asynchronous active-high reset (clears all stages)
//   clr    in   synchronous clear (between frames)
//   en     in   shift enable (datapath advance)
//   din    in   valid bit entering stage 0
//   dout   out  valid bit of the last stage
// -----------------------------------------------------------------------------
module sobel_vld_pipe #(
    parameter int DEPTH = 20
) (
    input  logic clk,
    input  logic areset,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] vld_sr_q;
    logic [DEPTH-1:0] vld_sr_d;
    logic [DEPTH-1:0] shift_in;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi == 0) begin : g_head
                assign shift_in[gi] = din;
            end else begin : g_tail
                assign shift_in[gi] = vld_sr_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        vld_sr_d = vld_sr_q;
        if (clr) begin
            vld_sr_d = '0;
        end else if (en) begin
            vld_sr_d = shift_in;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            vld_sr_q <= '0;
        end else begin
            vld_sr_q <= vld_sr_d;
        end
    end

    assign dout = vld_sr_q[DEPTH-1];

endmodule

// File: rtl/sobel_stream_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_stream_ctrl
// AXI-Stream sequencer around a stall-driven, fixed-latency, row-buffered
// Sobel datapath. Turns the two stream handshakes into one stall line, pushes
// one zero row through after each frame so the last row gets computed, drops
// the first output row so outputs line up with input rows, and tags output
// rows (m_tlast) and frames (m_tuser). The datapath is held in reset for one
// cycle between frames so its row/column state starts clean.
// Ports:
//   clk, areset                   clock / asynchronous active-high reset
//   s_tdata/valid/ready/user/last input stream (tuser = start of frame,
//                                 tlast = end of row)
//   m_tdata/valid/ready/user/last output stream (tuser = first beat of frame,
//                                 tlast = last beat of each row)
//   dp_stall                      datapath stall (1 = hold)
//   dp_aresetn                    datapath synchronous reset, active low
//   dp_inp_frame                  datapath input (zero during FLUSH/DRAIN)
//   dp_out_frame                  datapath output
//   err_len                       sticky framing error, cleared by areset
// -----------------------------------------------------------------------------
module sobel_stream_ctrl
    import sobel_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int DP_LATENCY      = 20
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tuser,
    input  logic                  s_tlast,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tuser,
    output logic                  m_tlast,
    output logic                  dp_stall,
    output logic                  dp_aresetn,
    output logic [DATA_WIDTH-1:0] dp_inp_frame,
    input  logic [DATA_WIDTH-1:0] dp_out_frame,
    output logic                  err_len
);

    localparam int BPR         = calc_bpr(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int FRAME_BEATS = BPR * IMAGE_DIM;
    localparam int COL_W       = clog2_min1(BPR);
    localparam int ROW_W       = clog2_min1(IMAGE_DIM);
    localparam int SKIP_W      = clog2_min1(BPR + 1);
    localparam int OCNT_W      = clog2_min1(FRAME_BEATS + 1);

    state_t              state_q,    state_d;
    logic [COL_W-1:0]    in_col_q,   in_col_d;
    logic [ROW_W-1:0]    in_row_q,   in_row_d;
    logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic [OCNT_W-1:0]   out_cnt_q,  out_cnt_d;
    logic [COL_W-1:0]    out_col_q,  out_col_d;
    logic                sent_q,     sent_d;
    logic                err_len_q,  err_len_d;

    logic ov;
    logic drop;
    logic hold;
    logic xfer;
    logic can_move;
    logic adv;
    logic col_last;
    logic row_last;
    logic first_beat;
    logic st_run;

    assign st_run = (state_q == ST_RUN);

    // Output side. The first row of each frame's datapath output is the
    // product of the zero row above the image and is thrown away; dropped
    // beats never present valid, so they cannot create back-pressure.
    assign drop = ov & (skip_cnt_q < SKIP_W'(BPR));
    // sent_q masks a beat that the sink already took while the pipeline could
    // not move (RUN with no input): the datapath keeps presenting the same
    // data, and without the mask the sink would receive it twice.
    assign m_tvalid = ov & ~drop & ~sent_q;
    assign m_tdata  = dp_out_frame;
    assign m_tuser  = m_tvalid & (out_cnt_q == '0);
    assign m_tlast  = m_tvalid & (out_col_q == COL_W'(BPR - 1));
    assign hold     = m_tvalid & ~m_tready;
    assign xfer     = m_tvalid & m_tready;

    assign can_move = (st_run & s_tvalid) | (state_q == ST_FLUSH) | (state_q == ST_DRAIN);
    assign adv      = ~hold & can_move;

    assign dp_stall     = ~adv;
    assign dp_aresetn   = (state_q != ST_CLR);
    assign dp_inp_frame = st_run ? s_tdata : '0;
    assign err_len      = err_len_q;

    assign col_last   = (in_col_q == COL_W'(BPR - 1));
    assign row_last   = (in_row_q == ROW_W'(IMAGE_DIM - 1));
    assign first_beat = (in_col_q == '0) && (in_row_q == '0);

    sobel_vld_pipe #(
        .DEPTH (DP_LATENCY)
    ) u_vld_pipe (
        .clk    (clk),
        .areset (areset),
        .clr    (state_q == ST_CLR),
        .en     (adv),
        .din    (st_run | (state_q == ST_FLUSH)),
        .dout   (ov)
    );

    always_comb begin
        state_d    = state_q;
        in_col_d   = in_col_q;
        in_row_d   = in_row_q;
        skip_cnt_d = skip_cnt_q;
        out_cnt_d  = out_cnt_q;
        out_col_d  = out_col_q;
        sent_d     = sent_q;
        err_len_d  = err_len_q;
        s_tready   = 1'b0;

        case (state_q)
            ST_CLR: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // Junk before start-of-frame is swallowed; the start-of-frame
                // beat itself is left on the bus for RUN to take.
                s_tready = ~(s_tvalid & s_tuser);
                if (s_tvalid & s_tuser) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_tready = ~hold;
                // In RUN an advance is exactly an accepted input beat.
                if (adv) begin
                    if ((s_tlast != col_last) || (s_tuser && !first_beat)) begin
                        err_len_d = 1'b1;
                    end
                    if (col_last) begin
                        in_col_d = '0;
                        if (row_last) begin
                            in_row_d = '0;
                            state_d  = ST_FLUSH;
                        end else begin
                            in_row_d = in_row_q + 1'b1;
                        end
                    end else begin
                        in_col_d = in_col_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                // The column counter is idle here and doubles as the count of
                // zero beats pushed.
                if (adv) begin
                    if (col_last) begin
                        in_col_d = '0;
                        state_d  = ST_DRAIN;
                    end else begin
                        in_col_d = in_col_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer && (out_cnt_q == OCNT_W'(FRAME_BEATS - 1))) begin
                    state_d = ST_CLR;
                end
            end
            default: begin
                state_d = ST_CLR;
            end
        endcase

        if (adv & drop) begin
            skip_cnt_d = skip_cnt_q + 1'b1;
        end

        if (xfer) begin
            out_cnt_d = out_cnt_q + 1'b1;
            out_col_d = (out_col_q == COL_W'(BPR - 1)) ? '0 : out_col_q + 1'b1;
        end

        if (adv) begin
            sent_d = 1'b0;
        end else if (xfer) begin
            sent_d = 1'b1;
        end

        if (state_q == ST_CLR) begin
            in_col_d   = '0;
            in_row_d   = '0;
            skip_cnt_d = '0;
            out_cnt_d  = '0;
            out_col_d  = '0;
            sent_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_CLR;
            in_col_q   <= '0;
            in_row_q   <= '0;
            skip_cnt_q <= '0;
            out_cnt_q  <= '0;
            out_col_q  <= '0;
            sent_q     <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_col_q   <= in_col_d;
            in_row_q   <= in_row_d;
            skip_cnt_q <= skip_cnt_d;
            out_cnt_q  <= out_cnt_d;
            out_col_q  <= out_col_d;
            sent_q     <= sent_d;
            err_len_q  <= err_len_d;
        end
    end

endmodule
